// File: rtl/dnn_train_sequencer_pkg.sv
// Shared types and width helpers for the DNN training sequencer slice.
package dnn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } sched_state_t;

  // $clog2 with a floor of one bit so degenerate parameters still give legal vectors
  function automatic int unsigned wbits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/dnn_train_sequencer_if.sv
// Control/status bundle between the bench-side controller and the training sequencer.
interface dnn_train_sequencer_if
  import dnn_sched_pkg::*;
#(
  parameter int unsigned CPC            = 18,
  parameter int unsigned TRAINING_CASES = 10000,
  parameter int unsigned EPOCHS         = 10,
  parameter int unsigned CHECKLAST      = 1000,
  localparam int unsigned CIW = wbits(CPC),
  localparam int unsigned NSW = wbits(CPC - 2),
  localparam int unsigned TCW = wbits(TRAINING_CASES),
  localparam int unsigned NTW = wbits(TRAINING_CASES * EPOCHS + 1),
  localparam int unsigned RW  = wbits(CHECKLAST + 1)
);
  logic           start;
  logic           halt;
  logic           result_valid;
  logic           result_correct;
  logic [CIW-1:0] cycle_index;
  logic           cycle_clk;
  logic [NSW-1:0] sel_network;
  logic           feed_en;
  logic [TCW-1:0] sel_tc;
  logic [15:0]    epoch;
  logic           epoch_done;
  logic [NTW-1:0] num_train;
  logic [RW-1:0]  recent_correct;
  logic [NTW-1:0] total_correct;
  logic           busy;
  logic           done;

  modport master (
    output start, halt, result_valid, result_correct,
    input  cycle_index, cycle_clk, sel_network, feed_en, sel_tc, epoch, epoch_done,
           num_train, recent_correct, total_correct, busy, done
  );

  modport slave (
    input  start, halt, result_valid, result_correct,
    output cycle_index, cycle_clk, sel_network, feed_en, sel_tc, epoch, epoch_done,
           num_train, recent_correct, total_correct, busy, done
  );
endinterface

// File: rtl/dnn_train_sequencer_acc_window.sv
// Sliding-window correct counter over the last CHECKLAST comparator verdicts.
module acc_window
  import dnn_sched_pkg::*;
#(
  parameter int unsigned CHECKLAST = 1000,
  localparam int unsigned RW = wbits(CHECKLAST + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          push,
  input  logic          bit_in,
  output logic [RW-1:0] recent
);
  localparam int unsigned PW = wbits(CHECKLAST);

  logic [CHECKLAST-1:0] win;
  logic [PW-1:0]        ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win    <= '0;
      ptr    <= '0;
      recent <= '0;
    end else if (clr) begin
      win    <= '0;
      ptr    <= '0;
      recent <= '0;
    end else if (push) begin
      // oldest verdict leaves the window as the new one enters
      recent   <= recent - RW'(win[ptr]) + RW'(bit_in);
      win[ptr] <= bit_in;
      ptr      <= (ptr == PW'(CHECKLAST - 1)) ? '0 : ptr + 1'b1;
    end
  end
endmodule

// File: rtl/dnn_train_sequencer.sv
// Block-cycle, training-case and epoch sequencing plus accuracy tracking for the DNN datapath.
module dnn_train_sequencer
  import dnn_sched_pkg::*;
#(
  parameter int unsigned CPC            = 18,
  parameter int unsigned TRAINING_CASES = 10000,
  parameter int unsigned EPOCHS         = 10,
  parameter int unsigned CHECKLAST      = 1000
) (
  input logic                  clk,
  input logic                  reset_n,
  dnn_train_sequencer_if.slave bus
);
  localparam int unsigned CIW = wbits(CPC);
  localparam int unsigned NSW = wbits(CPC - 2);
  localparam int unsigned TCW = wbits(TRAINING_CASES);
  localparam int unsigned NTW = wbits(TRAINING_CASES * EPOCHS + 1);
  localparam int unsigned RW  = wbits(CHECKLAST + 1);

  localparam logic [CIW-1:0] LAST_IDX = CIW'(CPC - 1);
  localparam logic [TCW-1:0] LAST_TC  = TCW'(TRAINING_CASES - 1);
  localparam logic [NTW-1:0] LAST_NT  = NTW'(TRAINING_CASES * EPOCHS - 1);

  sched_state_t   state;
  logic [CIW-1:0] idx_q;
  logic [TCW-1:0] tc_q;
  logic [15:0]    epoch_q;
  logic           epoch_done_q;
  logic [NTW-1:0] num_train_q;
  logic [NTW-1:0] total_q;
  logic [RW-1:0]  recent_q;
  logic           busy_q;
  logic           done_q;
  logic [CIW-1:0] idx_minus2;
  logic           clr;
  logic           push;

  assign clr  = bus.start && (state == IDLE || state == DONE);
  assign push = bus.result_valid && (state != IDLE) && !clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      idx_q        <= '0;
      tc_q         <= '0;
      epoch_q      <= '0;
      epoch_done_q <= 1'b0;
      num_train_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      epoch_done_q <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state       <= RUN;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            idx_q       <= '0;
            tc_q        <= '0;
            epoch_q     <= '0;
            num_train_q <= '0;
          end
        end
        PAUSED: begin
          if (bus.start) begin
            state  <= RUN;
            busy_q <= 1'b1;
          end
        end
        RUN: begin
          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (num_train_q != '1) num_train_q <= num_train_q + 1'b1;
            if (tc_q == LAST_TC) begin
              tc_q         <= '0;
              epoch_done_q <= 1'b1;
              if (epoch_q != '1) epoch_q <= epoch_q + 1'b1;
            end else begin
              tc_q <= tc_q + 1'b1;
            end
            // completion outranks a pending halt on the final boundary
            if (num_train_q == LAST_NT) begin
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else if (bus.halt) begin
              state  <= PAUSED;
              busy_q <= 1'b0;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                           total_q <= '0;
    else if (clr)                                           total_q <= '0;
    else if (push && bus.result_correct && total_q != '1)   total_q <= total_q + 1'b1;
  end

  acc_window #(.CHECKLAST(CHECKLAST)) u_acc (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (clr),
    .push   (push),
    .bit_in (bus.result_correct),
    .recent (recent_q)
  );

  // feed select is forced to 0 outside RUN so every output reads 0 out of reset
  assign idx_minus2      = idx_q - CIW'(2);
  assign bus.sel_network = busy_q ? idx_minus2[NSW-1:0] : '0;
  assign bus.cycle_clk   = busy_q && (idx_q == LAST_IDX);

  assign bus.cycle_index    = idx_q;
  assign bus.feed_en        = busy_q;
  assign bus.sel_tc         = tc_q;
  assign bus.epoch          = epoch_q;
  assign bus.epoch_done     = epoch_done_q;
  assign bus.num_train      = num_train_q;
  assign bus.recent_correct = recent_q;
  assign bus.total_correct  = total_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
endmodule
